// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter with open-drain pin drive and device-ack check.
// Optional watchdog compiled in with `define PS2_HOST_TX_TIMEOUT_EN.
module ps2_host_tx #(
  parameter int CLK_HZ         = 50_000_000,
  parameter int INHIBIT_CYCLES = 5000,
  parameter int RTS_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 750_000
) (
  input  logic       clock_fpga,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       clock_key_in,
  input  logic       data_key_in,
  output logic       clock_key_oe,
  output logic       data_key_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err
);
  localparam int CMAX = INHIBIT_CYCLES > RTS_CYCLES ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SEND, ACK, RELEASE} state_t;
  if (INHIBIT_CYCLES < 1 || RTS_CYCLES < 1 || TIMEOUT_CYCLES < 1 || CLK_HZ < 1) begin : g_bad_param
    $error("ps2_host_tx: cycle parameters must be positive");
  end
  state_t      state_q;
  logic [2:0]  clk_s_q;
  logic [1:0]  dat_s_q;
  logic        fall_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]  idx_q;
  logic [7:0]  data_q;
  logic        par_q;
  logic        bit_now;
  logic        waiting;
  assign bit_now = idx_q == 4'd8 ? par_q : data_q[idx_q[2:0]];
  assign waiting = state_q == SEND || state_q == ACK || state_q == RELEASE;
`ifdef PS2_HOST_TX_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd_q;
  logic          wd_hit;
  assign wd_hit = waiting && wd_q == WW'(TIMEOUT_CYCLES - 1);
`endif
  always_ff @(posedge clock_fpga or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      clk_s_q      <= 3'b111;
      dat_s_q      <= 2'b11;
      fall_q       <= 1'b0;
      cnt_q        <= '0;
      idx_q        <= 4'd0;
      data_q       <= 8'd0;
      par_q        <= 1'b0;
      clock_key_oe <= 1'b0;
      data_key_oe  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      ack_err      <= 1'b0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
      wd_q         <= '0;
`endif
    end else begin
      clk_s_q <= {clk_s_q[1:0], clock_key_in};
      dat_s_q <= {dat_s_q[0], data_key_in};
      fall_q  <= clk_s_q[2] & ~clk_s_q[1];
      done    <= 1'b0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
      wd_q    <= (fall_q || !waiting) ? '0 : wd_q + 1'b1;
`endif
      case (state_q)
        IDLE: if (tx_start && !done) begin
          state_q      <= INHIBIT;
          data_q       <= tx_data;
          par_q        <= ~^tx_data;
          clock_key_oe <= 1'b1;
          busy         <= 1'b1;
          ack_err      <= 1'b0;
          cnt_q        <= '0;
        end
        INHIBIT: if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
          state_q     <= RTS;
          data_key_oe <= 1'b1;
          cnt_q       <= '0;
        end else cnt_q <= cnt_q + 1'b1;
        RTS: if (cnt_q == CW'(RTS_CYCLES - 1)) begin
          state_q      <= SEND;
          clock_key_oe <= 1'b0;
          idx_q        <= 4'd0;
        end else cnt_q <= cnt_q + 1'b1;
        SEND: if (fall_q) begin
          data_key_oe <= idx_q == 4'd9 ? 1'b0 : ~bit_now;
          idx_q       <= idx_q + 1'b1;
          if (idx_q == 4'd9) state_q <= ACK;
        end
        ACK: if (fall_q) begin
          ack_err <= dat_s_q[1];
          state_q <= RELEASE;
        end
        RELEASE: if (clk_s_q[1] && dat_s_q[1]) begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
`ifdef PS2_HOST_TX_TIMEOUT_EN
      if (wd_hit) begin
        clock_key_oe <= 1'b0;
        data_key_oe  <= 1'b0;
        done         <= 1'b1;
        busy         <= 1'b0;
        ack_err      <= 1'b1;
        state_q      <= IDLE;
      end
`endif
    end
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with an open-drain PS/2 device model.
module tb_ps2_host_tx;
  localparam int H = 100;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'd0;
  logic       tx_start = 1'b0;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       ck_pin, dt_pin;
  logic       clock_key_oe, data_key_oe, busy, done, ack_err;
  int         vectors = 0;
  int         errs = 0;
  assign ck_pin = ~(clock_key_oe | dev_clk_low);
  assign dt_pin = ~(data_key_oe | dev_dat_low);
  always #5 clk = ~clk;
  ps2_host_tx #(.INHIBIT_CYCLES(5000), .RTS_CYCLES(16), .TIMEOUT_CYCLES(2000)) dut (
    .clock_fpga(clk), .reset(rst_n), .tx_data(tx_data), .tx_start(tx_start),
    .clock_key_in(ck_pin), .data_key_in(dt_pin), .clock_key_oe(clock_key_oe),
    .data_key_oe(data_key_oe), .busy(busy), .done(done), .ack_err(ack_err));
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic start_tx(input logic [7:0] d);
    int hi;
    @(negedge clk);
    tx_data = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    check("busy_rise", busy, 1);
    check("ack_err_clr", ack_err, 0);
    hi = 0;
    while (clock_key_oe === 1'b1 && hi < 20000) begin
      hi++;
      @(negedge clk);
    end
    check("clk_oe_high", hi, 5016);
    check("start_bit_oe", data_key_oe, 1);
  endtask
  task automatic dev_frame(input logic ack_low, input logic poke, output logic [10:0] smp);
    repeat (20) @(negedge clk);
    smp[0] = dt_pin;
    for (int k = 1; k <= 10; k++) begin
      dev_clk_low = 1'b1;
      if (poke && k == 5) begin
        tx_data = 8'h00;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (H - 1) @(negedge clk);
      end else repeat (H) @(negedge clk);
      dev_clk_low = 1'b0;
      smp[k] = dt_pin;
      repeat (H) @(negedge clk);
    end
    dev_dat_low = ack_low;
    repeat (5) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (H) @(negedge clk);
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
  endtask
  task automatic finish_tx(input logic exp_err);
    int c;
    c = 0;
    while (done !== 1'b1 && c < 2000) begin
      c++;
      @(negedge clk);
    end
    check("done_seen", done, 1);
    check("ack_err", ack_err, exp_err);
    check("busy_fall", busy, 0);
    check("oe_released", {clock_key_oe, data_key_oe}, 0);
    @(negedge clk);
    check("done_single", done, 0);
    check("ack_err_hold", ack_err, exp_err);
  endtask
  initial begin
    logic [10:0] smp;
    logic        seen;
    int          c;
    repeat (3) @(negedge clk);
    check("rst_outputs", {clock_key_oe, data_key_oe, busy, done, ack_err}, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    start_tx(8'hED);
    dev_frame(1'b1, 1'b0, smp);
    check("bits_ED", smp, 11'h7DA);
    finish_tx(1'b0);
    start_tx(8'h01);
    dev_frame(1'b1, 1'b0, smp);
    check("bits_01", smp, 11'h402);
    finish_tx(1'b0);
    start_tx(8'hFF);
    dev_frame(1'b0, 1'b0, smp);
    check("bits_FF", smp, 11'h7FE);
    finish_tx(1'b1);
    repeat (10) @(negedge clk);
    check("nack_idle", {clock_key_oe, data_key_oe, ack_err}, 3'b001);
    start_tx(8'h5A);
    dev_frame(1'b1, 1'b1, smp);
    check("bits_5A_poked", smp, 11'h6B4);
    finish_tx(1'b0);
    repeat (3) @(negedge clk);
    check("no_restart", {clock_key_oe, busy}, 0);
    start_tx(8'hA5);
    repeat (20) @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (H) @(negedge clk);
    end
    dev_clk_low = 1'b1;
    repeat (H / 2) @(negedge clk);
    check("pre_reset_oe", data_key_oe, 1);
    #2 rst_n = 1'b0;
    #1 check("reset_async_oe", {clock_key_oe, data_key_oe, busy}, 0);
    dev_clk_low = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    rst_n = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    check("no_done_on_reset", seen, 0);
    start_tx(8'hA5);
    dev_frame(1'b1, 1'b0, smp);
    check("bits_A5", smp, 11'h74A);
    finish_tx(1'b0);
`ifdef PS2_HOST_TX_TIMEOUT_EN
    start_tx(8'h55);
    c = 0;
    while (done !== 1'b1 && c < 5000) begin
      @(negedge clk);
      c++;
    end
    check("timeout_cycles", c, 2000);
    check("timeout_err", ack_err, 1);
    check("timeout_release", {clock_key_oe, data_key_oe, busy}, 0);
`else
    c = 0;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
